ps2_kbd_decoder: RTL and testbench
==================================

Name: ps2_kbd_decoder

Overview:
- Downstream consumer of the PS/2 host receive path. Takes completed bytes (rx_data with a 1-cycle rx_ready strobe) and decodes scan code set 2 prefix sequences (E0, F0, E1).
- Queues key events (code, extended, break) in a small first-word-fall-through (FWFT) FIFO for the CPU, and tracks modifier and caps-lock state.
- Filters keyboard protocol/status bytes out of the key stream.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- rx_data  in  8  received scan byte; valid only while rx_ready=1.
- rx_ready  in  1  1-cycle strobe, one per received byte.
- rd_req  in  1  pop the head event; ignored when empty.
- ovf_clr  in  1  clears the overflow flag.
- ev_code  out  8  head event scan code.
- ev_ext  out  1  head event had an E0 prefix.
- ev_brk  out  1  head event is a release.
- ev_valid  out  1  FIFO not empty.
- fifo_count  out  CNT_W  number of queued events.
- overflow  out  1  sticky; an event was dropped.
- shift, ctrl, alt  out  1  held-modifier state (left OR right).
- caps_lock  out  1  caps-lock toggle state.
- bat_ok  out  1  1-cycle pulse when 0xAA is received in IDLE.
- kbd_ack  out  1  1-cycle pulse when 0xFA is received in IDLE.

Behaviour:
- Reset values:
  - FSM = IDLE; FIFO empty.
  - All outputs 0, including ev_code/ev_ext/ev_brk (head reads as 0 when empty).
  - Internal held flags for lshift, rshift, lctrl, rctrl, lalt, ralt and caps_held are cleared.
- Bytes are processed only in a cycle where rx_ready=1. All state updates on the rising edge of clk.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE, skip counter = 7.
  - AA -> pulse bat_ok; FA -> pulse kbd_ack.
  - 00, EE, FC, FE, FF -> discarded; remain IDLE.
  - Any other byte -> push {ext=0, brk=0, code}; remain IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - 12 -> discarded (fake shift); -> IDLE.
  - Any other byte -> push {1, 0, code}; -> IDLE.
- BRK: any byte -> push {0, 1, code}; -> IDLE.
- EXT_BRK:
  - 12 -> discarded; -> IDLE.
  - Any other byte -> push {1, 1, code}; -> IDLE.
- PAUSE:
  - Each received byte decrements the skip counter.
  - The byte that brings it to 0 pushes {ext=1, brk=0, code=E1}; -> IDLE.
  - Bytes are not interpreted while in PAUSE (FA/AA are not pulsed).
- Modifiers (updated on the same edge as the push, from the decoded event):
  - 12 sets/clears lshift; 59 rshift; 14 lctrl; E0 14 rctrl; 11 lalt; E0 11 ralt. Make sets, break clears.
  - shift = lshift|rshift; ctrl and alt likewise.
- Caps lock:
  - A make of 58 with caps_held=0 toggles caps_lock and sets caps_held.
  - A break of 58 clears caps_held.
  - Typematic repeats therefore do not toggle.
- Latency: a byte strobed in cycle N that completes an event is visible at the FIFO head (ev_valid=1) and in the modifier outputs in cycle N+1. bat_ok/kbd_ack pulse in cycle N+1.
- FIFO (FWFT):
  - ev_* always reflect the head entry. rd_req with ev_valid=1 advances the head on that edge.
  - Push and pop in the same cycle: both take effect and fifo_count is unchanged. This includes the full case (pop frees the slot the push uses).
  - Pop while empty: ignored.
  - Push while full without pop: event dropped, overflow set. Modifier/caps state is still updated.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: cleared by ovf_clr or rst. If ovf_clr and a drop occur in the same cycle, set wins.
- Reset mid-sequence (e.g., after E0) returns the FSM to IDLE; the next byte decodes as unprefixed.
- The event stream is never blocked: an rx_ready strobe is always consumed in the cycle it occurs.

Decomposition:
- Package ps2_kbd_pkg:
  - Byte constants SC_EXT=E0, SC_BRK=F0, SC_PAUSE=E1, SC_BAT=AA, SC_ACK=FA.
  - Modifier codes 12, 59, 14, 11, 58.
  - FSM state enum.
  - Packed struct kbd_event_t {ext, brk, code[7:0]}.
- One sub-module: ps2_event_fifo (parameterised, FWFT, count/full/empty), instanced with kbd_event_t width 10.

Test Plan:
- Strobe 1C -> ev_valid=1 next cycle, head {code=1C, ext=0, brk=0}, fifo_count=1. Then F0,1C -> second entry {1C, 0, 1}, count=2.
- Strobe E0,F0,75 -> single entry {75, 1, 1}. Strobe E0,12,E0,7C -> only {7C, 1, 0} queued.
- Strobe 12, then 59, then F0 12 -> shift stays 1. Then F0 59 -> shift=0. Strobe 58 three times, then F0 58, then 58 -> caps_lock goes 1 and stays 1 through repeats, then 0 after the second make.
- Strobe E1,14,77,E1,F0,14,F0,77 -> exactly one entry {E1, 1, 0}; no ctrl change.
- Push 9 makes with FIFO_DEPTH=8 and no reads -> count=8, overflow=1, head is the first code. Pop while pushing at full -> count remains 8, overflow unchanged. ovf_clr -> overflow=0.
- Strobe AA then FA -> bat_ok and kbd_ack each pulse for 1 cycle; FIFO stays empty. Assert rst after E0, then strobe 1C -> entry {1C, 0, 0}.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 scan code set 2 keyboard decoder.
// Holds prefix/status byte values, modifier key codes, the decoder FSM state
// enum and the packed key event record stored in the event FIFO.
package ps2_kbd_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  // Keyboard status / protocol bytes
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_ACK   = 8'hFA;
  localparam logic [7:0] SC_ERR0  = 8'h00;
  localparam logic [7:0] SC_ECHO  = 8'hEE;
  localparam logic [7:0] SC_BATF  = 8'hFC;
  localparam logic [7:0] SC_RESND = 8'hFE;
  localparam logic [7:0] SC_ERR1  = 8'hFF;

  // Modifier key codes (make codes, set 2)
  localparam logic [7:0] MOD_LSHIFT = 8'h12;
  localparam logic [7:0] MOD_RSHIFT = 8'h59;
  localparam logic [7:0] MOD_CTRL   = 8'h14;
  localparam logic [7:0] MOD_ALT    = 8'h11;
  localparam logic [7:0] MOD_CAPS   = 8'h58;

  // Bytes that follow E1 before the pause sequence completes
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } kbd_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through FIFO for decoded key events.
// Ports: wr_vld/wr_dat push, rd_vld pop request, rd_dat head (0 when empty),
// full/empty/count status. Push is accepted when not full or when popping.
module ps2_event_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [W-1:0]     wr_dat,
  input  logic             rd_vld,
  output logic [W-1:0]     rd_dat,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             rd_en;
  logic             wr_en;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign count = cnt_q;

  // A pop at full frees the slot the simultaneous push lands in.
  assign rd_en = rd_vld & ~empty;
  assign wr_en = wr_vld & (~full | rd_en);

  // Head is masked so it reads as zero while empty (storage is not reset).
  assign rd_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 scan code set 2 decoder: turns received bytes into key events in a FWFT
// FIFO, tracks shift/ctrl/alt/caps-lock and pulses on BAT-complete and ACK.
// Ports: rx_data/rx_ready byte strobe in; rd_req pops head (ev_*); ovf_clr
// clears sticky overflow; modifier and status pulse outputs.
module ps2_kbd_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_ready,
  input  logic             rd_req,
  input  logic             ovf_clr,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_brk,
  output logic             ev_valid,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  output logic             shift,
  output logic             ctrl,
  output logic             alt,
  output logic             caps_lock,
  output logic             bat_ok,
  output logic             kbd_ack
);

  kbd_state_t state_q, state_d;
  logic [2:0] skip_q;

  logic       push_vld;
  kbd_event_t push_ev;
  logic       bat_d, ack_d;

  logic       lshift, rshift, lctrl, rctrl, lalt, ralt, caps_held;

  kbd_event_t head;
  logic [$bits(kbd_event_t)-1:0] head_raw;
  logic       fifo_full, fifo_empty;
  logic       drop;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (rx_ready) begin
      case (state_q)
        ST_IDLE: begin
          case (rx_data)
            SC_EXT:   state_d = ST_EXT;
            SC_BRK:   state_d = ST_BRK;
            SC_PAUSE: state_d = ST_PAUSE;
            default:  state_d = ST_IDLE;
          endcase
        end
        ST_EXT:     state_d = (rx_data == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
        ST_BRK:     state_d = ST_IDLE;
        ST_EXT_BRK: state_d = ST_IDLE;
        ST_PAUSE:   state_d = (skip_q == 3'd1) ? ST_IDLE : ST_PAUSE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs (event push, status pulses) ----------------
  always_comb begin
    push_vld = 1'b0;
    push_ev  = '0;
    bat_d    = 1'b0;
    ack_d    = 1'b0;
    if (rx_ready) begin
      case (state_q)
        ST_IDLE: begin
          case (rx_data)
            SC_EXT, SC_BRK, SC_PAUSE: ;
            SC_BAT: bat_d = 1'b1;
            SC_ACK: ack_d = 1'b1;
            SC_ERR0, SC_ECHO, SC_BATF, SC_RESND, SC_ERR1: ;
            default: begin
              push_vld = 1'b1;
              push_ev  = '{ext: 1'b0, brk: 1'b0, code: rx_data};
            end
          endcase
        end
        ST_EXT: begin
          // E0 12 is the fake shift some keyboards wrap around nav keys.
          if (rx_data != SC_BRK && rx_data != MOD_LSHIFT) begin
            push_vld = 1'b1;
            push_ev  = '{ext: 1'b1, brk: 1'b0, code: rx_data};
          end
        end
        ST_BRK: begin
          push_vld = 1'b1;
          push_ev  = '{ext: 1'b0, brk: 1'b1, code: rx_data};
        end
        ST_EXT_BRK: begin
          if (rx_data != MOD_LSHIFT) begin
            push_vld = 1'b1;
            push_ev  = '{ext: 1'b1, brk: 1'b1, code: rx_data};
          end
        end
        ST_PAUSE: begin
          // Pause/Break is reported once, as an extended make of E1.
          if (skip_q == 3'd1) begin
            push_vld = 1'b1;
            push_ev  = '{ext: 1'b1, brk: 1'b0, code: SC_PAUSE};
          end
        end
        default: ;
      endcase
    end
  end

  // Pause skip counter: loaded on E1 in IDLE, counts bytes down in PAUSE.
  always_ff @(posedge clk) begin
    if (rst) begin
      skip_q <= '0;
    end else if (rx_ready) begin
      if (state_q == ST_IDLE && rx_data == SC_PAUSE) begin
        skip_q <= PAUSE_SKIP;
      end else if (state_q == ST_PAUSE) begin
        skip_q <= skip_q - 3'd1;
      end
    end
  end

  // Status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      bat_ok  <= 1'b0;
      kbd_ack <= 1'b0;
    end else begin
      bat_ok  <= bat_d;
      kbd_ack <= ack_d;
    end
  end

  // Modifier tracking follows decoded events even when the FIFO drops them.
  always_ff @(posedge clk) begin
    if (rst) begin
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      lctrl     <= 1'b0;
      rctrl     <= 1'b0;
      lalt      <= 1'b0;
      ralt      <= 1'b0;
      caps_held <= 1'b0;
      caps_lock <= 1'b0;
    end else if (push_vld) begin
      if (!push_ev.ext) begin
        case (push_ev.code)
          MOD_LSHIFT: lshift <= ~push_ev.brk;
          MOD_RSHIFT: rshift <= ~push_ev.brk;
          MOD_CTRL:   lctrl  <= ~push_ev.brk;
          MOD_ALT:    lalt   <= ~push_ev.brk;
          default: ;
        endcase
      end else begin
        case (push_ev.code)
          MOD_CTRL: rctrl <= ~push_ev.brk;
          MOD_ALT:  ralt  <= ~push_ev.brk;
          default: ;
        endcase
      end
      // caps_held suppresses toggling on typematic repeats of the make.
      if (push_ev.code == MOD_CAPS) begin
        if (push_ev.brk) begin
          caps_held <= 1'b0;
        end else if (!caps_held) begin
          caps_held <= 1'b1;
          caps_lock <= ~caps_lock;
        end
      end
    end
  end

  assign shift = lshift | rshift;
  assign ctrl  = lctrl | rctrl;
  assign alt   = lalt | ralt;

  // ---------------- Event FIFO ----------------
  ps2_event_fifo #(
    .W     ($bits(kbd_event_t)),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (push_vld),
    .wr_dat (push_ev),
    .rd_vld (rd_req),
    .rd_dat (head_raw),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign head     = kbd_event_t'(head_raw);
  assign ev_code  = head.code;
  assign ev_ext   = head.ext;
  assign ev_brk   = head.brk;
  assign ev_valid = ~fifo_empty;

  // A push at full only survives if a pop frees a slot in the same cycle.
  assign drop = push_vld & fifo_full & ~(rd_req & ~fifo_empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Self-checking bench for ps2_kbd_decoder: directed sequences then random bytes,
// checked against a prefix-flag reference decoder and a queue model of the FIFO.
// Head entries are compared by a monitor at every pop.
module tb_ps2_kbd_decoder;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready = 1'b0;
  logic          rd_req = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [7:0]    ev_code;
  logic          ev_ext, ev_brk, ev_valid;
  logic [CW-1:0] fifo_count;
  logic          overflow, shift, ctrl, alt, caps_lock, bat_ok, kbd_ack;

  ps2_kbd_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .rd_req(rd_req), .ovf_clr(ovf_clr), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_brk(ev_brk), .ev_valid(ev_valid), .fifo_count(fifo_count),
    .overflow(overflow), .shift(shift), .ctrl(ctrl), .alt(alt),
    .caps_lock(caps_lock), .bat_ok(bat_ok), .kbd_ack(kbd_ack)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Expected FIFO contents, each entry {ext, brk, code}
  logic [9:0] exp_q[$];

  // Reference model state
  bit m_ext, m_brk;
  int m_pause;
  bit m_lsh, m_rsh, m_lct, m_rct, m_lal, m_ral, m_caps, m_held, m_ovf;
  bit e_bat, e_ack;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ext = 0; m_brk = 0; m_pause = 0;
    m_lsh = 0; m_rsh = 0; m_lct = 0; m_rct = 0; m_lal = 0; m_ral = 0;
    m_caps = 0; m_held = 0; m_ovf = 0; e_bat = 0; e_ack = 0;
  endtask

  // Monitor: every pop of a non-empty FIFO must deliver the oldest expected event.
  always @(negedge clk) begin
    if (!rst && rd_req && ev_valid) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 1, 0);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("pop_head", {ev_ext, ev_brk, ev_code}, e);
      end
    end
  end

  // Compare all visible state against the model (called #1 after a rising edge).
  task automatic check_state();
    chk("ev_valid", ev_valid, exp_q.size() > 0);
    chk("fifo_count", fifo_count, exp_q.size());
    if (exp_q.size() == 0) chk("head_empty", {ev_ext, ev_brk, ev_code}, 0);
    else                   chk("head", {ev_ext, ev_brk, ev_code}, exp_q[0]);
    chk("overflow", overflow, m_ovf);
    chk("shift", shift, m_lsh | m_rsh);
    chk("ctrl", ctrl, m_lct | m_rct);
    chk("alt", alt, m_lal | m_ral);
    chk("caps_lock", caps_lock, m_caps);
    chk("bat_ok", bat_ok, e_bat);
    chk("kbd_ack", kbd_ack, e_ack);
  endtask

  task automatic model_event(input bit ext, input bit brk, input logic [7:0] code, input bit rd,
                             output bit dropped);
    dropped = 0;
    if (!ext) begin
      if (code == 8'h12) m_lsh = !brk;
      if (code == 8'h59) m_rsh = !brk;
      if (code == 8'h14) m_lct = !brk;
      if (code == 8'h11) m_lal = !brk;
    end else begin
      if (code == 8'h14) m_rct = !brk;
      if (code == 8'h11) m_ral = !brk;
    end
    if (code == 8'h58) begin
      if (brk) m_held = 0;
      else if (!m_held) begin m_held = 1; m_caps = !m_caps; end
    end
    // Queue size here is the pre-pop occupancy; a pop happens iff non-empty.
    if (exp_q.size() < DEPTH || (rd && exp_q.size() > 0)) exp_q.push_back({ext, brk, code});
    else dropped = 1;
  endtask

  // One clock cycle: check, drive inputs, advance the model, wait for the edge.
  task automatic step(input bit v, input logic [7:0] b, input bit rd, input bit clr);
    bit dropped;
    check_state();
    rx_ready = v; rx_data = b; rd_req = rd; ovf_clr = clr;
    e_bat = 0; e_ack = 0; dropped = 0;
    if (v) begin
      if (m_pause > 0) begin
        m_pause--;
        if (m_pause == 0) model_event(1, 0, 8'hE1, rd, dropped);
      end else if (!m_ext && !m_brk) begin
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE1) m_pause = 7;
        else if (b == 8'hAA) e_bat = 1;
        else if (b == 8'hFA) e_ack = 1;
        else if (b inside {8'h00, 8'hEE, 8'hFC, 8'hFE, 8'hFF}) ;
        else model_event(0, 0, b, rd, dropped);
      end else if (!m_brk) begin
        if (b == 8'hF0) m_brk = 1;
        else begin
          m_ext = 0;
          if (b != 8'h12) model_event(1, 0, b, rd, dropped);
        end
      end else begin
        if (!(m_ext && b == 8'h12)) model_event(m_ext, 1, b, rd, dropped);
        m_ext = 0; m_brk = 0;
      end
    end
    if (dropped) m_ovf = 1;
    else if (clr) m_ovf = 0;
    @(posedge clk); #1;
  endtask

  task automatic kb(input logic [7:0] b);
    step(1, b, 0, 0);
  endtask

  task automatic idle();
    step(0, 8'h00, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && exp_q.size() > 0; i++) step(0, 8'h00, 1, 0);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1; rx_ready = 0; rd_req = 0; ovf_clr = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  localparam int NPOOL = 20;
  logic [7:0] pool [NPOOL] = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h00, 8'hEE, 8'h12,
                               8'h59, 8'h14, 8'h11, 8'h58, 8'h1C, 8'h75, 8'h7C, 8'hE0,
                               8'hF0, 8'h12, 8'h58, 8'h6B};

  initial begin
    model_reset();
    do_reset();
    idle();

    // Plain make then break
    kb(8'h1C); idle();
    kb(8'hF0); kb(8'h1C); idle();
    drain();

    // Extended break, and fake-shift filtering
    kb(8'hE0); kb(8'hF0); kb(8'h75); idle();
    kb(8'hE0); kb(8'h12); kb(8'hE0); kb(8'h7C); idle();
    drain();

    // Shift held across L/R, caps-lock typematic
    kb(8'h12); kb(8'h59); kb(8'hF0); kb(8'h12); idle();
    kb(8'hF0); kb(8'h59); idle();
    kb(8'h58); kb(8'h58); kb(8'h58); kb(8'hF0); kb(8'h58); kb(8'h58); idle();
    drain();

    // Pause sequence
    foreach (pool[i]) ;
    kb(8'hE1); kb(8'h14); kb(8'h77); kb(8'hE1); kb(8'hF0); kb(8'h14); kb(8'hF0); kb(8'h77);
    idle();
    drain();

    // Overflow, pop+push at full, clear
    for (int i = 0; i < DEPTH + 1; i++) kb(8'h20 + 8'(i));
    idle();
    step(1, 8'h3C, 1, 0); idle();
    step(0, 8'h00, 0, 1); idle();
    drain();

    // Status bytes
    kb(8'hAA); idle(); kb(8'hFA); idle(); idle();

    // Reset mid-sequence
    kb(8'hE0);
    do_reset();
    kb(8'h1C); idle();
    drain();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit v, rd, clr;
      logic [7:0] b;
      v   = ($urandom_range(0, 3) != 0);
      b   = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, NPOOL - 1)];
      rd  = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 19) == 0);
      step(v, b, rd, clr);
    end
    idle();
    drain();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
